// File: rtl/fabric_frame_loader_pkg.sv
// Shared constants, address-word field helpers and loader state encoding
// for the fabric configuration frame loader.
package fabric_frame_loader_pkg;

    localparam logic [31:0] syncWord   = 32'hFAB0_FAB1;
    localparam logic [31:0] desyncWord = 32'hFAB0_FAB0;

    // Address word layout: [31:24] column, [23:5] reserved, [4:0] frame index.
    localparam int colMsb   = 31;
    localparam int colLsb   = 24;
    localparam int frameMsb = 4;
    localparam int frameLsb = 0;
    localparam int colW     = colMsb - colLsb + 1;
    localparam int frameW   = frameMsb - frameLsb + 1;

    typedef enum logic [1:0] {
        stIdle = 2'd0,
        stAddr = 2'd1,
        stData = 2'd2
    } loaderState_e;

    function automatic logic [colW-1:0] addrCol(input logic [31:0] word);
        return word[colMsb:colLsb];
    endfunction

    function automatic logic [frameW-1:0] addrFrame(input logic [31:0] word);
        return word[frameMsb:frameLsb];
    endfunction

endpackage

// File: rtl/fabric_frame_loader_frame_strobe_decoder.sv
// Registered one-hot frame strobe: bit col*MaxFramesPerCol+frame pulses for
// one cycle after fire, only when the captured address was valid.
module frame_strobe_decoder
    import fabric_frame_loader_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfCols    = 16
) (
    input  logic                                CLK,
    input  logic                                resetn,
    input  logic [colW-1:0]                     col,
    input  logic [frameW-1:0]                   frame,
    input  logic                                valid,
    input  logic                                fire,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe
);

    localparam int strobeW = NumberOfCols * MaxFramesPerCol;

    logic [31:0]        target;
    logic [strobeW-1:0] strobeNext;

    assign target = 32'(col) * 32'(MaxFramesPerCol) + 32'(frame);

    // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        strobeNext = '0;
        for (int i = 0; i < strobeW; i++) begin
            if (fire && valid && (32'(i) == target)) strobeNext[i] = 1'b1;
        end
    end

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!resetn) FrameStrobe <= '0;
        else         FrameStrobe <= strobeNext;
    end

endmodule

// File: rtl/fabric_frame_loader.sv
// Bitstream word loader: finds sync, decodes frame addresses, assembles a
// frame column into FrameData and fires one strobe bit per completed frame.
module fabric_frame_loader
    import fabric_frame_loader_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfRows    = 16,
    parameter int NumberOfCols    = 16
) (
    input  logic                                    CLK,
    input  logic                                    resetn,
    input  logic [31:0]                             WriteData,
    input  logic                                    WriteStrobe,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                    Busy,
    output logic                                    Configured,
    output logic                                    ConfigError
);

    if (FrameBitsPerRow != 32) begin : gBadRowWidth
        $error("fabric_frame_loader: FrameBitsPerRow must be 32");
    end

    localparam int rowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam logic [rowW-1:0] lastRow = rowW'(NumberOfRows - 1);

    loaderState_e      state, nextState;
    logic [rowW-1:0]   rowCnt;
    logic [colW-1:0]   colReg;
    logic [frameW-1:0] frameReg;
    logic              validReg;
    logic              addrValid;
    logic              loadAddr, writeRow, setConfigured, clrConfigured, fire;

    assign addrValid = (32'(addrCol(WriteData)) < 32'(NumberOfCols)) &&
                       (32'(addrFrame(WriteData)) < 32'(MaxFramesPerCol));
    assign Busy = (state != stIdle);

    always_ff @(posedge CLK) begin
        if (!resetn) state <= stIdle;
        else         state <= nextState;
    end

    // Idle cycles (WriteStrobe low) freeze the FSM wherever it is.
    always_comb begin
        nextState     = state;
        loadAddr      = 1'b0;
        writeRow      = 1'b0;
        setConfigured = 1'b0;
        clrConfigured = 1'b0;
        fire          = 1'b0;
        if (WriteStrobe) begin
            unique case (state)
                stIdle: begin
                    if (WriteData == syncWord) begin
                        nextState     = stAddr;
                        clrConfigured = 1'b1;
                    end
                end
                stAddr: begin
                    if (WriteData == syncWord) begin
                        nextState = stAddr;
                    end else if (WriteData == desyncWord) begin
                        nextState     = stIdle;
                        setConfigured = 1'b1;
                    end else begin
                        loadAddr  = 1'b1;
                        nextState = stData;
                    end
                end
                stData: begin
                    writeRow = 1'b1;
                    if (rowCnt == lastRow) begin
                        fire      = 1'b1;
                        nextState = stAddr;
                    end
                end
                default: nextState = stIdle;
            endcase
        end
    end

    // NOTE: FrameData is a plain register bank (not a RAM), so it is cleared by reset like any other state.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            FrameData   <= '0;
            rowCnt      <= '0;
            colReg      <= '0;
            frameReg    <= '0;
            validReg    <= 1'b0;
            Configured  <= 1'b0;
            ConfigError <= 1'b0;
        end else begin
            if (clrConfigured) Configured <= 1'b0;
            if (setConfigured) Configured <= 1'b1;
            if (loadAddr) begin
                colReg   <= addrCol(WriteData);
                frameReg <= addrFrame(WriteData);
                validReg <= addrValid;
                rowCnt   <= '0;
                if (!addrValid) ConfigError <= 1'b1;
            end
            if (writeRow) begin
                FrameData[32'(rowCnt)*FrameBitsPerRow +: FrameBitsPerRow] <= WriteData;
                if (rowCnt != lastRow) rowCnt <= rowCnt + rowW'(1);
            end
        end
    end

    frame_strobe_decoder #(
        .MaxFramesPerCol(MaxFramesPerCol),
        .NumberOfCols   (NumberOfCols)
    ) uStrobe (
        .CLK        (CLK),
        .resetn     (resetn),
        .col        (colReg),
        .frame      (frameReg),
        .valid      (validReg),
        .fire       (fire),
        .FrameStrobe(FrameStrobe)
    );

endmodule

// File: tb/tb_fabric_frame_loader.sv
// Directed plus randomized bench for fabric_frame_loader, checked each cycle
// against a queue-based behavioural model of the bitstream protocol.
module tb_fabric_frame_loader;

    localparam int Rows = 4;
    localparam int Cols = 4;
    localparam int MaxF = 20;
    localparam int FW   = Rows * 32;
    localparam int SW   = Cols * MaxF;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   WriteData = '0;
    logic          WriteStrobe = 1'b0;
    logic [FW-1:0] FrameData;
    logic [SW-1:0] FrameStrobe;
    logic          Busy, Configured, ConfigError;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          mSynced, mHaveAddr, mConfigured, mErr;
    int          mCol, mFrame, mStrobeIdx;
    logic [31:0] mRow [Rows];
    logic [31:0] mWords[$];

    fabric_frame_loader #(
        .FrameBitsPerRow(32),
        .MaxFramesPerCol(MaxF),
        .NumberOfRows   (Rows),
        .NumberOfCols   (Cols)
    ) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .WriteData  (WriteData),
        .WriteStrobe(WriteStrobe),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .Busy       (Busy),
        .Configured (Configured),
        .ConfigError(ConfigError)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mSynced = 0; mHaveAddr = 0; mConfigured = 0; mErr = 0;
        mCol = 0; mFrame = 0; mStrobeIdx = -1;
        for (int r = 0; r < Rows; r++) mRow[r] = '0;
        mWords.delete();
    endtask

    // Applies the word seen at this clock edge to the protocol model.
    task automatic modelEdge();
        mStrobeIdx = -1;
        if (!resetn) begin
            modelReset();
        end else if (WriteStrobe) begin
            if (!mSynced) begin
                if (WriteData == SYNC) begin mSynced = 1; mConfigured = 0; end
            end else if (!mHaveAddr) begin
                if (WriteData == DESYNC) begin
                    mSynced = 0; mConfigured = 1;
                end else if (WriteData != SYNC) begin
                    mCol = int'(WriteData[31:24]);
                    mFrame = int'(WriteData[4:0]);
                    mHaveAddr = 1;
                    mWords.delete();
                    if (mCol >= Cols || mFrame >= MaxF) mErr = 1;
                end
            end else begin
                mRow[mWords.size()] = WriteData;
                mWords.push_back(WriteData);
                if (mWords.size() == Rows) begin
                    mHaveAddr = 0;
                    if (mCol < Cols && mFrame < MaxF) mStrobeIdx = mCol * MaxF + mFrame;
                end
            end
        end
    endtask

    task automatic step(input logic [31:0] w, input logic ws, input logic rst, input string tag);
        logic [FW-1:0] expData;
        logic [SW-1:0] expStrobe;
        @(negedge CLK);
        resetn = rst;
        WriteData = w;
        WriteStrobe = ws;
        @(posedge CLK);
        modelEdge();
        #1;
        for (int r = 0; r < Rows; r++) expData[r*32 +: 32] = mRow[r];
        expStrobe = '0;
        if (mStrobeIdx >= 0) expStrobe[mStrobeIdx] = 1'b1;
        check({tag, "_data"},   128'(FrameData),   128'(expData));
        check({tag, "_strobe"}, 128'(FrameStrobe), 128'(expStrobe));
        check({tag, "_busy"},   128'(Busy),        128'(mSynced));
        check({tag, "_cfg"},    128'(Configured),  128'(mConfigured));
        check({tag, "_err"},    128'(ConfigError), 128'(mErr));
    endtask

    task automatic sendFrame(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3, input string tag);
        step(addr, 1, 1, {tag, "_addr"});
        step(d0, 1, 1, {tag, "_d0"});
        step(d1, 1, 1, {tag, "_d1"});
        step(d2, 1, 1, {tag, "_d2"});
        step(d3, 1, 1, {tag, "_d3"});
    endtask

    initial begin
        modelReset();
        step('0, 0, 0, "rst0");
        step('0, 0, 0, "rst1");
        check("rst_all_zero", 128'({FrameStrobe, Busy, Configured, ConfigError}), 128'(0));

        // Words before sync are dropped
        step(32'h1234, 1, 1, "t2_junk");
        step(DESYNC, 1, 1, "t2_desync");
        check("t2_busy_low", 128'(Busy), 128'(0));
        step(SYNC, 1, 1, "t2_sync");
        check("t2_busy_high", 128'(Busy), 128'(1));

        // Valid frame col 2 frame 3
        sendFrame(32'h0200_0003, 32'h11, 32'h22, 32'h33, 32'h44, "t1");
        check("t1_bit43", 128'(FrameStrobe[43]), 128'(1));
        check("t1_framedata", 128'(FrameData), 128'h0000_0044_0000_0033_0000_0022_0000_0011);
        step('0, 0, 1, "t1_after");
        check("t1_one_cycle", 128'(FrameStrobe), 128'(0));

        // Out-of-range column, then a valid frame keeps the sticky error
        sendFrame(32'h0500_0001, 32'hA1, 32'hA2, 32'hA3, 32'hA4, "t3bad");
        check("t3_err_set", 128'(ConfigError), 128'(1));
        sendFrame(32'h0100_0013, 32'hB1, 32'hB2, 32'hB3, 32'hB4, "t3ok");
        check("t3_err_sticky", 128'(ConfigError), 128'(1));

        // Address in the strobe cycle, then gapped data
        step(32'h0300_0000, 1, 1, "t4_addr_in_strobe");
        step(32'hC1, 1, 1, "t4_d0");
        step(32'hDEAD, 0, 1, "t4_gap0");
        step(32'hC2, 1, 1, "t4_d1");
        step(32'hBEEF, 0, 1, "t4_gap1");
        step(32'hC3, 1, 1, "t4_d2");
        step(32'hC4, 1, 1, "t4_d3");

        // DESYNC as data, then DESYNC in ADDR
        sendFrame(32'h0000_0005, DESYNC, SYNC, 32'h5, 32'h6, "t5data");
        check("t5_busy_after_desync_data", 128'(Busy), 128'(1));
        step(DESYNC, 1, 1, "t5_desync");
        check("t5_busy", 128'(Busy), 128'(0));
        check("t5_cfg", 128'(Configured), 128'(1));

        // Reset mid-frame, then re-sync
        step(SYNC, 1, 1, "t6_sync");
        step(32'h0100_0002, 1, 1, "t6_addr");
        step(32'hE1, 1, 1, "t6_d0");
        step(32'hE2, 1, 1, "t6_d1");
        step('0, 0, 0, "t6_rst");
        check("t6_rst_zero", 128'({FrameData, FrameStrobe, Busy, Configured, ConfigError}), 128'(0));
        step(SYNC, 1, 1, "t6_resync");
        sendFrame(32'h0300_0013, 32'hF1, 32'hF2, 32'hF3, 32'hF4, "t6");

        // Randomized frames with gaps, invalid addresses and occasional resets
        for (int it = 0; it < 40; it++) begin
            logic [31:0] addr;
            if (!mSynced) step(SYNC, 1, 1, "rnd_sync");
            addr = {8'($urandom_range(0, 4)), 19'($urandom), 5'($urandom_range(0, 21))};
            if (addr == SYNC || addr == DESYNC) addr = 32'h0;
            step(addr, 1, 1, "rnd_addr");
            for (int k = 0; k < Rows; k++) begin
                logic [31:0] d;
                while ($urandom_range(0, 3) == 0) step($urandom, 0, 1, "rnd_gap");
                case ($urandom_range(0, 9))
                    0:       d = SYNC;
                    1:       d = DESYNC;
                    default: d = $urandom;
                endcase
                step(d, 1, 1, "rnd_data");
                if (k == 1 && $urandom_range(0, 11) == 0) step('0, 0, 0, "rnd_rst");
            end
            if ($urandom_range(0, 5) == 0) step(DESYNC, 1, 1, "rnd_desync");
        end
        step('0, 0, 1, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
